// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and reset-driven clear sequencer
module regfile_mp #(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [AW-1:0]     a3,
    input  logic [W-1:0]      wd3,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*W-1:0]   rd,
    output logic              ready
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] clr_idx_nxt;
    logic          ready_nxt;
    logic          clr_last;
    logic          wr_en;
    logic [W-1:0]  rf [DEPTH];

    assign clr_last = (clr_idx == AW'(DEPTH - 1));
    assign wr_en    = we3 && !((ZERO_REG != 0) && (a3 == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            ready   <= ready_nxt;
        end
    end

    // The index holds at DEPTH-1 once the sweep finishes, so there is no second pass.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        ready_nxt   = ready;
        case (state)
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            RUN: begin
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                rf[clr_idx] <= '0;
            end else if (wr_en) begin
                rf[a3] <= wd3;
            end
        end
    end

    // Zero register outranks the bypass; everything reads 0 until the clear completes.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] rai;
        logic [W-1:0]  rdi;

        assign rai = ra[i*AW +: AW];

        always_comb begin
            rdi = rf[rai];
            if (state == CLEAR) begin
                rdi = '0;
            end else if ((ZERO_REG != 0) && (rai == '0)) begin
                rdi = '0;
            end else if ((BYPASS != 0) && we3 && (a3 == rai)) begin
                rdi = wd3;
            end
        end

        assign rd[i*W +: W] = rdi;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [9:0]  ra;
    logic [63:0] rd_b;
    logic [63:0] rd_n;
    logic        ready_b;
    logic        ready_n;

    regfile_mp dut_b (
        .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
        .ra(ra), .rd(rd_b), .ready(ready_b)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
        .ra(ra), .rd(rd_n), .ready(ready_n)
    );

    logic         reset2;
    logic         we2;
    logic [3:0]   a2;
    logic [63:0]  wd2;
    logic [11:0]  ra2;
    logic [191:0] rd2;
    logic         ready2;

    regfile_mp #(.W(64), .AW(4), .NR(3), .ZERO_REG(0)) dut_w (
        .clk(clk), .reset(reset2), .we3(we2), .a3(a2), .wd3(wd2),
        .ra(ra2), .rd(rd2), .ready(ready2)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [32];
    int          mcnt  = 0;
    bit          mready = 1'b0;

    typedef struct {
        bit          we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e0nb;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a reset starts a DEPTH-edge clear; afterwards writes land unless aimed at x0.
    task automatic model_edge();
        if (reset) begin
            mcnt   = 0;
            mready = 1'b0;
        end else if (!mready) begin
            mem[mcnt] = 32'h0;
            mcnt++;
            if (mcnt == 32) mready = 1'b1;
        end else if (we3 && a3 != 5'd0) begin
            mem[a3] = wd3;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int port, input bit byp);
        logic [4:0] ad;
        ad = ra[port*5 +: 5];
        if (!mready)                    return 32'h0;
        if (ad == 5'd0)                 return 32'h0;
        if (byp && we3 && a3 == ad)     return wd3;
        return mem[ad];
    endfunction

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_ready_b"}, 64'(ready_b), 64'(mready));
        chk({tag, "_ready_n"}, 64'(ready_n), 64'(mready));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_rd_b%0d", tag, p), 64'(rd_b[p*32 +: 32]), 64'(exp_rd(p, 1'b1)));
            chk($sformatf("%s_rd_n%0d", tag, p), 64'(rd_n[p*32 +: 32]), 64'(exp_rd(p, 1'b0)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic count_clear(input string tag, input int want);
        int n;
        n = 0;
        while (!ready_b && n < 100) begin
            ra = 10'($urandom);
            check_all(tag);
            tick();
            n++;
        end
        chk({tag, "_len"}, 64'(n), 64'(want));
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vt[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vt[3] = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd7,  32'h11,       32'h11,       32'h0};
        vt[4] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 32'h11};
        vt[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'h22};
        vt[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h0};
        vt[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF};

        reset = 1'b1; we3 = 1'b0; a3 = '0; wd3 = '0; ra = '0;
        reset2 = 1'b1; we2 = 1'b0; a2 = '0; wd2 = '0; ra2 = '0;
        tick();
        tick();
        check_all("rst");

        // Clear with a write hammered at x3 the whole time.
        reset = 1'b0; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hFFFFFFFF;
        count_clear("clr", 32);
        we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra = {5'(i), 5'(i)};
            check_all("clr_read");
            chk($sformatf("zero_b_%0d", i), rd_b, 64'h0);
        end

        for (int i = 0; i < 8; i++) begin
            we3 = vt[i].we; a3 = vt[i].a; wd3 = vt[i].wd; ra = {vt[i].r1, vt[i].r0};
            #1;
            chk($sformatf("vec%0d_rd0", i), 64'(rd_b[31:0]),  64'(vt[i].e0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd_b[63:32]), 64'(vt[i].e1));
            chk($sformatf("vec%0d_nb0", i), 64'(rd_n[31:0]),  64'(vt[i].e0nb));
            tick();
        end
        we3 = 1'b0;

        we3 = 1'b1; a3 = 5'd9; wd3 = 32'hA5A5A5A5;
        tick();
        we3 = 1'b0; ra = {5'd9, 5'd9};
        check_all("pre_mid");
        chk("pre_mid_x9", 64'(rd_b[31:0]), 64'hA5A5A5A5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_all("mid");
            tick();
        end
        chk("mid_ready_low", 64'(ready_b), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_clear("mid_clr", 32);
        ra = {5'd9, 5'd9};
        check_all("post_mid");
        chk("post_mid_x9", 64'(rd_b[31:0]), 64'h0);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            we3   = 1'($urandom);
            a3    = 5'($urandom_range(0, 7));
            wd3   = $urandom;
            ra    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            check_all("rnd");
            tick();
        end
        reset = 1'b0; we3 = 1'b0;

        begin
            int n;
            tick();
            chk("w_rst_ready", 64'(ready2), 64'h0);
            reset2 = 1'b0;
            n = 0;
            while (!ready2 && n < 100) begin
                tick();
                n++;
            end
            chk("w_clr_len", 64'(n), 64'd16);
            we2 = 1'b1; a2 = 4'd0; wd2 = 64'h0123456789ABCDEF; ra2 = '0;
            #1;
            for (int p = 0; p < 3; p++)
                chk($sformatf("w_byp%0d", p), rd2[p*64 +: 64], 64'h0123456789ABCDEF);
            tick();
            we2 = 1'b0;
            #1;
            for (int p = 0; p < 3; p++)
                chk($sformatf("w_rd%0d", p), rd2[p*64 +: 64], 64'h0123456789ABCDEF);
            ra2 = {4'd1, 4'd15, 4'd0};
            #1;
            chk("w_rd_x15", rd2[127:64], 64'h0);
            chk("w_rd_x0",  rd2[63:0],   64'h0123456789ABCDEF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
